// File: rtl/icoder_scan.sv
// icoder_scan: registered scanning one-hot/multi-hot to binary encoder.
// Captures a 2**M-bit request vector over a valid/ready handshake and
// emits the binary index of each asserted bit, lowest index first, one
// index per output beat. Per-vector status (population count, one-hot,
// empty) is held constant across all beats of that vector.
module icoder_scan #(
    parameter int M          = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit MODE       = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [(2**M)-1:0]   in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [M-1:0]        out_idx,
    output logic                out_last,
    output logic                out_none,
    output logic                out_onehot,
    output logic [M:0]          out_cnt
);

    localparam int N = 2**M;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;

    logic [N-1:0]   r_pend;
    logic [M:0]     r_cnt;
    logic           r_onehot;
    logic           r_none;

    logic [N-1:0]   w_vec;
    logic [M:0]     w_popCnt;
    logic [M-1:0]   w_lowIdx;
    logic [N-1:0]   w_pendRest;
    logic           w_atMostOne;
    logic           w_accept;
    logic           w_beat;
    logic           w_lastBeat;

    // Bring the request vector to "1 means asserted" regardless of input polarity
    always_comb begin
        w_vec = ACTIVE_LOW ? ~in_vec : in_vec;
    end

    // Population count of the normalised vector, only used at capture time
    always_comb begin
        w_popCnt = '0;
        for (int i = 0; i < N; i++) begin
            w_popCnt = w_popCnt + {{M{1'b0}}, w_vec[i]};
        end
    end

    // Index of the lowest pending bit; scanning downward lets the lowest win, empty gives 0
    always_comb begin
        w_lowIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_lowIdx = i[M-1:0];
            end
        end
    end

    // Pending bits with the lowest one removed; zero means this is the final pending bit
    always_comb begin
        w_pendRest  = r_pend & (r_pend - {{(N-1){1'b0}}, 1'b1});
        w_atMostOne = (w_pendRest == '0);
    end

    // Output decode from the registered state; no path from in_vec reaches the outputs
    always_comb begin
        out_valid  = (r_state == SCAN);
        out_last   = (r_state == SCAN) && (!MODE || w_atMostOne);
        out_idx    = w_lowIdx;
        out_cnt    = r_cnt;
        out_onehot = r_onehot;
        out_none   = r_none;
        w_beat     = out_valid && out_ready;
        w_lastBeat = w_beat && out_last;
        in_ready   = !rst && ((r_state == IDLE) || w_lastBeat);
        w_accept   = in_valid && in_ready;
    end

    // Next-state logic: a fresh accept always scans, otherwise the last beat returns to idle
    always_comb begin
        w_stateNext = r_state;
        if (w_accept) begin
            w_stateNext = SCAN;
        end else if (w_lastBeat) begin
            w_stateNext = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Pending-bit register: load on accept, strip the emitted bit on each handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_pend <= w_vec;
        end else if (w_lastBeat) begin
            r_pend <= '0;
        end else if (w_beat) begin
            r_pend <= w_pendRest;
        end
    end

    // Per-vector status registers, captured once on accept and held for every beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_onehot <= 1'b0;
            r_none   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= w_popCnt;
            r_onehot <= (w_popCnt == {{M{1'b0}}, 1'b1});
            r_none   <= (w_vec == '0);
        end
    end

endmodule

// File: tb/tb_icoder_scan.sv
// tb_icoder_scan: directed self-checking bench for icoder_scan.
// Three instances cover the parameter corners: active-low scan (A),
// active-low priority (B) and active-high scan (C).
module tb_icoder_scan;

   logic clk;
   logic rst;

   logic        aInValid, aInReady, aOutValid, aOutReady, aOutLast, aOutNone, aOutOnehot;
   logic [15:0] aInVec;
   logic [3:0]  aOutIdx;
   logic [4:0]  aOutCnt;

   logic        bInValid, bInReady, bOutValid, bOutReady, bOutLast, bOutNone, bOutOnehot;
   logic [15:0] bInVec;
   logic [3:0]  bOutIdx;
   logic [4:0]  bOutCnt;

   logic        cInValid, cInReady, cOutValid, cOutReady, cOutLast, cOutNone, cOutOnehot;
   logic [15:0] cInVec;
   logic [3:0]  cOutIdx;
   logic [4:0]  cOutCnt;

   logic [12:0] obsA, obsB, obsC;

   int vectorCount;
   int missCount;

   icoder_scan #(.M(4), .ACTIVE_LOW(1'b1), .MODE(1'b1)) dutA (
      .clk(clk), .rst(rst),
      .in_valid(aInValid), .in_ready(aInReady), .in_vec(aInVec),
      .out_valid(aOutValid), .out_ready(aOutReady), .out_idx(aOutIdx),
      .out_last(aOutLast), .out_none(aOutNone), .out_onehot(aOutOnehot), .out_cnt(aOutCnt)
   );

   icoder_scan #(.M(4), .ACTIVE_LOW(1'b1), .MODE(1'b0)) dutB (
      .clk(clk), .rst(rst),
      .in_valid(bInValid), .in_ready(bInReady), .in_vec(bInVec),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_idx(bOutIdx),
      .out_last(bOutLast), .out_none(bOutNone), .out_onehot(bOutOnehot), .out_cnt(bOutCnt)
   );

   icoder_scan #(.M(4), .ACTIVE_LOW(1'b0), .MODE(1'b1)) dutC (
      .clk(clk), .rst(rst),
      .in_valid(cInValid), .in_ready(cInReady), .in_vec(cInVec),
      .out_valid(cOutValid), .out_ready(cOutReady), .out_idx(cOutIdx),
      .out_last(cOutLast), .out_none(cOutNone), .out_onehot(cOutOnehot), .out_cnt(cOutCnt)
   );

   // Pack each instance's beat as {valid, idx, last, none, onehot, cnt} for compact comparison
   always_comb begin
      obsA = {aOutValid, aOutIdx, aOutLast, aOutNone, aOutOnehot, aOutCnt};
      obsB = {bOutValid, bOutIdx, bOutLast, bOutNone, bOutOnehot, bOutCnt};
      obsC = {cOutValid, cOutIdx, cOutLast, cOutNone, cOutOnehot, cOutCnt};
   end

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reset values and in_ready release timing
   task automatic test_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      vectorCount++;
      if (obsA !== 13'h0) begin
         missCount++;
         $display("[TB] FAIL reset_outputs: got %h want %h", obsA, 13'h0);
      end
      vectorCount++;
      if (aInReady !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL reset_in_ready_low: got %b want 0", aInReady);
      end
      vectorCount++;
      if ({bOutValid, cOutValid} !== 2'b00) begin
         missCount++;
         $display("[TB] FAIL reset_bc_valid: got %b want 00", {bOutValid, cOutValid});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectorCount++;
      if (aInReady !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL reset_release_in_ready: got %b want 1", aInReady);
      end
      @(posedge clk);
      #1;
   endtask

   // Single-bit sweep on the active-low scan instance
   task automatic test_sweep();
      for (int i = 0; i < 16; i++) begin
         aInVec   = ~(16'h0001 << i);
         aInValid = 1'b1;
         @(posedge clk);
         #1;
         aInValid = 1'b0;
         @(negedge clk);
         vectorCount++;
         if (obsA !== {1'b1, 4'(i), 1'b1, 1'b0, 1'b1, 5'd1}) begin
            missCount++;
            $display("[TB] FAIL sweep_bit%0d: got %h want %h", i, obsA, {1'b1, 4'(i), 1'b1, 1'b0, 1'b1, 5'd1});
         end
         @(posedge clk);
         #1;
         vectorCount++;
         if (aOutValid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL sweep_idle%0d: got valid %b want 0", i, aOutValid);
         end
      end
   endtask

   // Multi-bit vector in scan mode (A) and in priority mode (B)
   task automatic test_multi();
      logic [12:0] expBeat [3];
      expBeat[0] = {1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 5'd3};
      expBeat[1] = {1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 5'd3};
      expBeat[2] = {1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 5'd3};
      aInVec   = 16'h7F6F;
      aInValid = 1'b1;
      bInVec   = 16'h7F6F;
      bInValid = 1'b1;
      @(posedge clk);
      #1;
      aInValid = 1'b0;
      bInValid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectorCount++;
         if (obsA !== expBeat[k]) begin
            missCount++;
            $display("[TB] FAIL multi_scan_beat%0d: got %h want %h", k, obsA, expBeat[k]);
         end
         if (k == 0) begin
            vectorCount++;
            if (obsB !== {1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 5'd3}) begin
               missCount++;
               $display("[TB] FAIL multi_prio_beat: got %h want %h", obsB, {1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 5'd3});
            end
         end
         if (k == 1) begin
            vectorCount++;
            if (bOutValid !== 1'b0) begin
               missCount++;
               $display("[TB] FAIL multi_prio_single: got valid %b want 0", bOutValid);
            end
         end
         @(posedge clk);
         #1;
      end
      vectorCount++;
      if (aOutValid !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL multi_scan_done: got valid %b want 0", aOutValid);
      end
   endtask

   // Empty vector and fully asserted vector boundaries
   task automatic test_bounds();
      aInVec   = 16'hFFFF;
      aInValid = 1'b1;
      @(posedge clk);
      #1;
      aInValid = 1'b0;
      @(negedge clk);
      vectorCount++;
      if (obsA !== {1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 5'd0}) begin
         missCount++;
         $display("[TB] FAIL empty_beat: got %h want %h", obsA, {1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 5'd0});
      end
      @(posedge clk);
      #1;
      vectorCount++;
      if (aOutValid !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL empty_single: got valid %b want 0", aOutValid);
      end
      aInVec   = 16'h0000;
      aInValid = 1'b1;
      @(posedge clk);
      #1;
      aInValid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         vectorCount++;
         if (obsA !== {1'b1, 4'(i), (i == 15), 1'b0, 1'b0, 5'd16}) begin
            missCount++;
            $display("[TB] FAIL full_beat%0d: got %h want %h", i, obsA, {1'b1, 4'(i), (i == 15), 1'b0, 1'b0, 5'd16});
         end
         @(posedge clk);
         #1;
      end
      vectorCount++;
      if (aOutValid !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL full_done: got valid %b want 0", aOutValid);
      end
   endtask

   // Backpressure on idx 7 and a second vector accepted on the idx-15 handshake
   task automatic test_back_to_back();
      aInVec   = 16'h7F6F;
      aInValid = 1'b1;
      @(posedge clk);
      #1;
      aInVec   = 16'hFFFE;
      @(negedge clk);
      vectorCount++;
      if ({obsA, aInReady} !== {1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0}) begin
         missCount++;
         $display("[TB] FAIL bp_beat4: got %h want %h", {obsA, aInReady}, {1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0});
      end
      @(posedge clk);
      #1;
      aOutReady = 1'b0;
      for (int h = 0; h < 4; h++) begin
         if (h == 3) begin
            aOutReady = 1'b1;
         end
         @(negedge clk);
         vectorCount++;
         if ({obsA, aInReady} !== {1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0}) begin
            missCount++;
            $display("[TB] FAIL bp_hold7_cycle%0d: got %h want %h", h, {obsA, aInReady}, {1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0});
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      vectorCount++;
      if ({obsA, aInReady} !== {1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1}) begin
         missCount++;
         $display("[TB] FAIL bp_beat15: got %h want %h", {obsA, aInReady}, {1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1});
      end
      @(posedge clk);
      #1;
      aInValid = 1'b0;
      @(negedge clk);
      vectorCount++;
      if (obsA !== {1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 5'd1}) begin
         missCount++;
         $display("[TB] FAIL b2b_second_beat: got %h want %h", obsA, {1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 5'd1});
      end
      @(posedge clk);
      #1;
      vectorCount++;
      if (aOutValid !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL b2b_done: got valid %b want 0", aOutValid);
      end
   endtask

   // Synchronous reset in the middle of a scan discards the remaining bits
   task automatic test_mid_reset();
      aInVec   = 16'h7F6F;
      aInValid = 1'b1;
      @(posedge clk);
      #1;
      aInValid = 1'b0;
      @(negedge clk);
      vectorCount++;
      if (obsA !== {1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 5'd3}) begin
         missCount++;
         $display("[TB] FAIL midrst_beat4: got %h want %h", obsA, {1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 5'd3});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      vectorCount++;
      if (aInReady !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL midrst_in_ready: got %b want 0", aInReady);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectorCount++;
      if ({obsA, aInReady} !== {13'h0, 1'b1}) begin
         missCount++;
         $display("[TB] FAIL midrst_cleared: got %h want %h", {obsA, aInReady}, {13'h0, 1'b1});
      end
      for (int w = 0; w < 3; w++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         vectorCount++;
         if (aOutValid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL midrst_no_beat%0d: got valid %b want 0", w, aOutValid);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Active-high polarity on instance C
   task automatic test_active_high();
      cInVec   = 16'h8001;
      cInValid = 1'b1;
      @(posedge clk);
      #1;
      cInValid = 1'b0;
      @(negedge clk);
      vectorCount++;
      if (obsC !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd2}) begin
         missCount++;
         $display("[TB] FAIL ahigh_beat0: got %h want %h", obsC, {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd2});
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      vectorCount++;
      if (obsC !== {1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 5'd2}) begin
         missCount++;
         $display("[TB] FAIL ahigh_beat15: got %h want %h", obsC, {1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 5'd2});
      end
      @(posedge clk);
      #1;
      vectorCount++;
      if (cOutValid !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL ahigh_done: got valid %b want 0", cOutValid);
      end
   endtask

   // Test sequence
   initial begin
      vectorCount = 0;
      missCount   = 0;
      rst         = 1'b1;
      aInValid = 1'b0; aInVec = 16'hFFFF; aOutReady = 1'b1;
      bInValid = 1'b0; bInVec = 16'hFFFF; bOutReady = 1'b1;
      cInValid = 1'b0; cInVec = 16'h0000; cOutReady = 1'b1;
      test_reset();
      test_sweep();
      test_multi();
      test_bounds();
      test_back_to_back();
      test_mid_reset();
      test_active_high();
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
